// File: rtl/output_deskew_16_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// output_deskew_16_if : row-deskew bus (skewed columns in, aligned rows out)
// Revision 1.0
// ---------------------------------------------------------------------------
interface output_deskew_16_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COL_COUNT  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                            flush;
  logic [COL_COUNT-1:0]            in_valid;
  logic [COL_COUNT*DATA_WIDTH-1:0] data_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [COL_COUNT*DATA_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]                row_count;
  logic                            full;
  logic                            overflow;
  logic                            misalign;

  modport master (
    output flush, in_valid, data_in, out_ready,
    input  out_valid, data_out, row_count, full, overflow, misalign
  );

  modport slave (
    input  flush, in_valid, data_in, out_ready,
    output out_valid, data_out, row_count, full, overflow, misalign
  );
endinterface
`default_nettype wire

// File: rtl/output_deskew_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// output_deskew_16 : removes per-column systolic stagger, buffers aligned rows
// Revision 1.0
// ---------------------------------------------------------------------------
module output_deskew_16 #(
  parameter int DATA_WIDTH = 32,
  parameter int COL_COUNT  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  output_deskew_16_if.slave  bus
);
  localparam int ROW_W = COL_COUNT * DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [COL_COUNT-1:0] row_v;
  logic [ROW_W-1:0]     row_d;

  // Column i is delayed COL_COUNT-1-i cycles so every column lines up with
  // the last one, which enters the aligner directly.
  for (genvar i = 0; i < COL_COUNT; i++) begin : g_col
    localparam int DEPTH = COL_COUNT - 1 - i;
    if (DEPTH == 0) begin : g_pass
      assign row_v[i]                           = bus.in_valid[i];
      assign row_d[i*DATA_WIDTH +: DATA_WIDTH]  = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DEPTH-1:0]      vld_q, vld_d;
      logic [DATA_WIDTH-1:0] dat_q [DEPTH];
      logic [DATA_WIDTH-1:0] dat_d [DEPTH];

      always_comb begin
        vld_d = '0;
        for (int k = 0; k < DEPTH; k++) dat_d[k] = '0;
        if (!bus.flush) begin
          vld_d[0] = bus.in_valid[i];
          dat_d[0] = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          for (int k = 0; k < DEPTH; k++) dat_q[k] <= '0;
        end else begin
          vld_q <= vld_d;
          for (int k = 0; k < DEPTH; k++) dat_q[k] <= dat_d[k];
        end
      end

      assign row_v[i]                          = vld_q[DEPTH-1];
      assign row_d[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[DEPTH-1];
    end
  end

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [ROW_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d, misalign_q, misalign_d;

  logic row_push, row_mixed, is_full, head_valid, pop, wr_en;

  assign row_push   = &row_v;
  assign row_mixed  = (|row_v) & ~row_push;
  assign is_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & bus.out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign wr_en      = row_push & (~is_full | pop);

  always_comb begin
    for (int k = 0; k < FIFO_DEPTH; k++) mem_d[k] = mem_q[k];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    misalign_d = misalign_q;
    if (bus.flush) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_d[k] = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      misalign_d = 1'b0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = row_d;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      if (row_push & is_full & ~pop) overflow_d = 1'b1;
      if (row_mixed) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= mem_d[k];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.out_valid = head_valid;
  assign bus.data_out  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.row_count = count_q;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.misalign  = misalign_q;
endmodule
`default_nettype wire

// File: tb/tb_output_deskew_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_output_deskew_16 : directed bench for output_deskew_16
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_output_deskew_16;
  localparam int DW = 32;
  localparam int CC = 16;
  localparam int FD = 4;
  localparam int RW = DW * CC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_deskew_16_if #(.DATA_WIDTH(DW), .COL_COUNT(CC), .FIFO_DEPTH(FD)) bus ();

  output_deskew_16 #(.DATA_WIDTH(DW), .COL_COUNT(CC), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  // Producer history: entry k is the row that started k cycles ago.
  bit hv  [CC+1];
  int hid [CC+1];
  int skew_col = -1;
  bit mdl_on = 1'b0;
  bit m_ovf  = 1'b0;
  int mq[$];

  function automatic logic [RW-1:0] exp_row(input int id);
    logic [RW-1:0] r;
    for (int i = 0; i < CC; i++) r[i*DW +: DW] = DW'(id * 256 + i + 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, RW'(bus.out_valid), '0);
    chk({tag, "_data"},  bus.data_out,        '0);
    chk({tag, "_count"}, RW'(bus.row_count), '0);
    chk({tag, "_full"},  RW'(bus.full),      '0);
    chk({tag, "_ovf"},   RW'(bus.overflow),  '0);
    chk({tag, "_mis"},   RW'(bus.misalign),  '0);
  endtask

  task automatic drive();
    int src;
    for (int i = 0; i < CC; i++) begin
      src = (i == skew_col) ? i + 1 : i;
      bus.in_valid[i]        = hv[src];
      bus.data_in[i*DW +: DW] = hv[src] ? DW'(hid[src] * 256 + i + 1) : '0;
    end
  endtask

  task automatic clr_hist();
    for (int k = 0; k <= CC; k++) begin
      hv[k]  = 1'b0;
      hid[k] = 0;
    end
    drive();
  endtask

  task automatic cyc(input bit st, input int id);
    bit pop;
    for (int k = CC; k > 0; k--) begin
      hv[k]  = hv[k-1];
      hid[k] = hid[k-1];
    end
    hv[0]  = st;
    hid[0] = id;
    drive();
    if (mdl_on) begin
      pop = (mq.size() != 0) && bus.out_ready;
      if (pop) void'(mq.pop_front());
      if (hv[CC-1]) begin
        if (mq.size() < FD) mq.push_back(hid[CC-1]);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_count"}, RW'(bus.row_count), RW'(mq.size()));
    chk({tag, "_data"},  bus.data_out, (mq.size() != 0) ? exp_row(mq[0]) : '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    clr_hist();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    // Single aligned row, consumer ready.
    bus.out_ready = 1'b1;
    cyc(1'b1, 0);
    idle(14);
    chk("t1_early", RW'(bus.out_valid), '0);
    cyc(1'b0, 0);
    chk("t1_valid", RW'(bus.out_valid), RW'(1));
    chk("t1_data",  bus.data_out, exp_row(0));
    chk("t1_mis",   RW'(bus.misalign), '0);
    cyc(1'b0, 0);
    chk("t1_gone",  RW'(bus.out_valid), '0);

    // Fill, overflow, drain in order.
    bus.out_ready = 1'b0;
    for (int r = 1; r <= 4; r++) cyc(1'b1, r);
    idle(20);
    chk("t2_count", RW'(bus.row_count), RW'(4));
    chk("t2_full",  RW'(bus.full), RW'(1));
    chk("t2_head",  bus.data_out, exp_row(1));
    cyc(1'b1, 5);
    idle(20);
    chk("t2_ovf",   RW'(bus.overflow), RW'(1));
    chk("t2_count4", RW'(bus.row_count), RW'(4));
    bus.out_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      chk("t2_drain", bus.data_out, exp_row(r));
      cyc(1'b0, 0);
    end
    chk("t2_empty", RW'(bus.out_valid), '0);
    chk("t2_zdata", bus.data_out, '0);

    // Push into a full FIFO while popping.
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    cyc(1'b0, 0);
    bus.flush     = 1'b0;
    chk("t3_flush_ovf", RW'(bus.overflow), '0);
    for (int r = 11; r <= 14; r++) cyc(1'b1, r);
    idle(20);
    chk("t3_full", RW'(bus.full), RW'(1));
    cyc(1'b1, 15);
    idle(14);
    bus.out_ready = 1'b1;
    cyc(1'b0, 0);
    bus.out_ready = 1'b0;
    chk("t3_count", RW'(bus.row_count), RW'(4));
    chk("t3_ovf",   RW'(bus.overflow), '0);
    chk("t3_head",  bus.data_out, exp_row(12));
    bus.out_ready = 1'b1;
    for (int r = 12; r <= 15; r++) begin
      chk("t3_drain", bus.data_out, exp_row(r));
      cyc(1'b0, 0);
    end
    chk("t3_empty", RW'(bus.out_valid), '0);

    // Column 3 one cycle late.
    bus.out_ready = 1'b0;
    skew_col = 3;
    cyc(1'b1, 20);
    idle(20);
    skew_col = -1;
    chk("t4_mis",   RW'(bus.misalign), RW'(1));
    chk("t4_count", RW'(bus.row_count), '0);
    cyc(1'b1, 21);
    idle(15);
    chk("t4_next_count", RW'(bus.row_count), RW'(1));
    chk("t4_next_data",  bus.data_out, exp_row(21));
    bus.out_ready = 1'b1;
    cyc(1'b0, 0);
    chk("t4_gone",   RW'(bus.out_valid), '0);
    chk("t4_sticky", RW'(bus.misalign), RW'(1));

    // Asynchronous reset with rows in the FIFO and the delay lines.
    bus.out_ready = 1'b0;
    cyc(1'b1, 30);
    cyc(1'b1, 31);
    idle(20);
    cyc(1'b1, 32);
    idle(5);
    chk("t5_pre", RW'(bus.row_count), RW'(2));
    #2 rst = 1'b1;
    #1;
    chk_zero("t5_arst");
    clr_hist();
    #2 rst = 1'b0;
    repeat (20) begin
      cyc(1'b0, 0);
      chk("t5_stale", RW'(bus.out_valid), '0);
    end
    chk("t5_mis", RW'(bus.misalign), '0);

    // Same scenario cleared by flush, which also overrides a pending pop.
    cyc(1'b1, 40);
    cyc(1'b1, 41);
    idle(20);
    cyc(1'b1, 42);
    idle(5);
    chk("t5f_pre", RW'(bus.row_count), RW'(2));
    for (int k = 0; k <= CC; k++) hv[k] = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    cyc(1'b0, 0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    chk_zero("t5_flush");
    repeat (20) begin
      cyc(1'b0, 0);
      chk("t5f_stale", RW'(bus.out_valid), '0);
    end

    // Continuous stream, consumer ready on alternate cycles.
    mq.delete();
    m_ovf  = 1'b0;
    mdl_on = 1'b1;
    for (int k = 0; k < 64; k++) begin
      bus.out_ready = (k % 2 == 0);
      cyc(1'b1, 100 + k);
      chk_model("t6_stream");
    end
    for (int k = 0; k < 40; k++) begin
      bus.out_ready = (k % 2 == 0);
      cyc(1'b0, 0);
      chk_model("t6_tail");
    end
    chk("t6_ovf",   RW'(bus.overflow), RW'(m_ovf));
    chk("t6_empty", RW'(bus.out_valid), '0);
    chk("t6_mis",   RW'(bus.misalign), '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
